// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: decode-to-execute stage. Resolves source operands by
// forwarding from EX/MEM/WB, inserts a single bubble on a load-use hazard and
// registers the result into the ID/EX register behind a valid/ready handshake.
module operand_fetch_stage #(
  parameter logic [4:0] XZR   = 5'd31,
  parameter int         CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  // decode side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic             in_regwrite,
  input  logic             in_memread,
  input  logic             in_use_imm,
  input  logic [63:0]      in_imm,
  input  logic [63:0]      rf_data1,
  input  logic [63:0]      rf_data2,
  // EX producer
  input  logic             ex_valid,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic [63:0]      ex_result,
  // MEM producer
  input  logic             mem_valid,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_rd,
  input  logic [63:0]      mem_result,
  // WB producer (regfile write port this cycle)
  input  logic             wb_valid,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic [63:0]      wb_data,
  // control
  input  logic             flush,
  // ID/EX register
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_opa,
  output logic [63:0]      out_opb,
  output logic [4:0]       out_rd,
  output logic             out_regwrite,
  output logic             out_memread,
  output logic [63:0]      out_store_data,
  output logic [CNT_W-1:0] stall_count
);

  // Forwarding priority: zero register, then youngest producer first.
  function automatic logic [63:0] fwd(
    input logic [4:0]  src,
    input logic [63:0] rf,
    input logic        exv, input logic exw, input logic [4:0] exd, input logic [63:0] exr,
    input logic        mev, input logic mew, input logic [4:0] med, input logic [63:0] mer,
    input logic        wbv, input logic wbw, input logic [4:0] wbd, input logic [63:0] wbr
  );
    if (src == XZR)                         return 64'd0;
    else if (exv && exw && (exd == src))    return exr;
    else if (mev && mew && (med == src))    return mer;
    else if (wbv && wbw && (wbd == src))    return wbr;
    else                                    return rf;
  endfunction

  logic             valid_q, valid_d;
  logic [63:0]      opa_q, opa_d;
  logic [63:0]      opb_q, opb_d;
  logic [63:0]      store_q, store_d;
  logic [4:0]       rd_q, rd_d;
  logic             regwrite_q, regwrite_d;
  logic             memread_q, memread_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [63:0] fwd1, fwd2;
  logic        load_use;
  logic        load_en;

  // Operand resolution and hazard detection for the decode instruction.
  always_comb begin
    fwd1 = fwd(in_rs1, rf_data1,
               ex_valid, ex_regwrite, ex_rd, ex_result,
               mem_valid, mem_regwrite, mem_rd, mem_result,
               wb_valid, wb_regwrite, wb_rd, wb_data);
    fwd2 = fwd(in_rs2, rf_data2,
               ex_valid, ex_regwrite, ex_rd, ex_result,
               mem_valid, mem_regwrite, mem_rd, mem_result,
               wb_valid, wb_regwrite, wb_rd, wb_data);
    // A load in EX cannot be forwarded yet; rs2 only matters when it feeds B
    // (the store-data path resolves one cycle later via MEM forwarding).
    load_use = in_valid && ex_valid && ex_memread && ex_regwrite && (ex_rd != XZR) &&
               ((ex_rd == in_rs1) || ((ex_rd == in_rs2) && !in_use_imm));
    load_en  = !valid_q || out_ready;
    in_ready = flush ? 1'b1 : (load_en && !load_use);
  end

  // Next-state for the ID/EX register and the stall counter.
  always_comb begin
    // NOTE: every variable gets a hold value first so no path infers a latch.
    valid_d    = valid_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    store_d    = store_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    cnt_d      = cnt_q;

    if (flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
    end else if (load_en) begin
      valid_d    = in_valid && !load_use;
      opa_d      = fwd1;
      opb_d      = in_use_imm ? in_imm : fwd2;
      store_d    = fwd2;
      rd_d       = in_rd;
      // Bubbles and empty slots must never look like a writer downstream.
      regwrite_d = in_regwrite && in_valid && !load_use;
      memread_d  = in_memread && in_valid && !load_use;
      if (load_use && (cnt_q != {CNT_W{1'b1}}))
        cnt_d = cnt_q + 1'b1;
    end
  end

  // ID/EX register and stall counter.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the payload is reset too, so outputs read as zero straight out of reset.
    if (!reset_n) begin
      valid_q    <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      store_q    <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      valid_q    <= valid_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      store_q    <= store_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_opa        = opa_q;
  assign out_opb        = opb_q;
  assign out_store_data = store_q;
  assign out_rd         = rd_q;
  assign out_regwrite   = regwrite_q;
  assign out_memread    = memread_q;
  assign stall_count    = cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Testbench for operand_fetch_stage: directed cases plus randomized traffic,
// all checked against a cycle-level behavioural model of the stage.
module tb_operand_fetch_stage;

  localparam int CNT_W = 3;   // small so saturation is reachable
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid, in_ready;
  logic [4:0]       in_rs1, in_rs2, in_rd;
  logic             in_regwrite, in_memread, in_use_imm;
  logic [63:0]      in_imm, rf_data1, rf_data2;
  logic             ex_valid, ex_regwrite, ex_memread;
  logic [4:0]       ex_rd;
  logic [63:0]      ex_result;
  logic             mem_valid, mem_regwrite;
  logic [4:0]       mem_rd;
  logic [63:0]      mem_result;
  logic             wb_valid, wb_regwrite;
  logic [4:0]       wb_rd;
  logic [63:0]      wb_data;
  logic             flush;
  logic             out_valid, out_ready;
  logic [63:0]      out_opa, out_opb, out_store_data;
  logic [4:0]       out_rd;
  logic             out_regwrite, out_memread;
  logic [CNT_W-1:0] stall_count;

  operand_fetch_stage #(.XZR(5'd31), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_regwrite(in_regwrite), .in_memread(in_memread), .in_use_imm(in_use_imm),
    .in_imm(in_imm), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .ex_result(ex_result),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .mem_result(mem_result),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opa(out_opa), .out_opb(out_opb), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .out_memread(out_memread),
    .out_store_data(out_store_data), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // State of the ID/EX register as the pipeline contract describes it.
  logic             m_valid;
  logic [63:0]      m_opa, m_opb, m_store;
  logic [4:0]       m_rd;
  logic             m_rw, m_mr;
  logic             m_ctl_known;  // control bits are defined (reset, bubble, flush, valid)
  logic [CNT_W-1:0] m_cnt;

  // Value a source register should see: zero register, else the youngest
  // in-flight writer of that register, else the regfile read.
  function automatic logic [63:0] m_source(input logic [4:0] s, input logic [63:0] rf);
    logic        pv [3];
    logic [4:0]  pd [3];
    logic [63:0] px [3];
    pv[0] = ex_valid  && ex_regwrite;  pd[0] = ex_rd;  px[0] = ex_result;
    pv[1] = mem_valid && mem_regwrite; pd[1] = mem_rd; px[1] = mem_result;
    pv[2] = wb_valid  && wb_regwrite;  pd[2] = wb_rd;  px[2] = wb_data;
    if (s == 5'd31) return 64'd0;
    for (int p = 0; p < 3; p++)
      if (pv[p] && pd[p] == s) return px[p];
    return rf;
  endfunction

  function automatic logic m_load_use();
    logic needs_rs1, needs_rs2;
    if (!(in_valid && ex_valid && ex_memread && ex_regwrite) || ex_rd == 5'd31) return 1'b0;
    needs_rs1 = (in_rs1 == ex_rd);
    needs_rs2 = (in_rs2 == ex_rd) && !in_use_imm;
    return needs_rs1 || needs_rs2;
  endfunction

  task automatic m_reset();
    m_valid = 0; m_opa = 0; m_opb = 0; m_store = 0; m_rd = 0;
    m_rw = 0; m_mr = 0; m_ctl_known = 1; m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, out_valid, m_valid);
    check({tag, ".stalls"}, stall_count, m_cnt);
    if (m_ctl_known) begin
      check({tag, ".regwrite"}, out_regwrite, m_rw);
      check({tag, ".memread"}, out_memread, m_mr);
    end
    if (m_valid) begin
      check({tag, ".opa"}, out_opa, m_opa);
      check({tag, ".opb"}, out_opb, m_opb);
      check({tag, ".store"}, out_store_data, m_store);
      check({tag, ".rd"}, out_rd, m_rd);
    end
  endtask

  // One clock: inputs already driven (away from the edge); check in_ready,
  // advance the model, take the edge, then check the registered outputs.
  task automatic step(input string tag);
    logic lu, can_load;
    #1;
    lu       = m_load_use();
    can_load = !m_valid || out_ready;
    check({tag, ".in_ready"}, in_ready, flush ? 1'b1 : (can_load && !lu));
    if (flush) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_ctl_known = 1;
    end else if (can_load) begin
      if (lu) begin
        m_valid = 0; m_rw = 0; m_mr = 0; m_ctl_known = 1;
        if (m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
      end else if (in_valid) begin
        m_valid = 1;
        m_opa   = m_source(in_rs1, rf_data1);
        m_store = m_source(in_rs2, rf_data2);
        m_opb   = in_use_imm ? in_imm : m_store;
        m_rd    = in_rd;
        m_rw    = in_regwrite;
        m_mr    = in_memread;
        m_ctl_known = 1;
      end else begin
        m_valid = 0; m_ctl_known = 0;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic clear_inputs();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_regwrite = 0; in_memread = 0; in_use_imm = 0;
    in_imm = 0; rf_data1 = 0; rf_data2 = 0;
    ex_valid = 0; ex_regwrite = 0; ex_memread = 0; ex_rd = 0; ex_result = 0;
    mem_valid = 0; mem_regwrite = 0; mem_rd = 0; mem_result = 0;
    wb_valid = 0; wb_regwrite = 0; wb_rd = 0; wb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  // Register indices clustered on a few values so hazards are frequent.
  function automatic logic [4:0] rnd_reg();
    int r;
    r = $urandom_range(0, 7);
    return (r == 7) ? 5'd31 : 5'(r);
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic randomize_inputs();
    in_valid    = ($urandom_range(0, 9) < 8);
    in_rs1      = rnd_reg();
    in_rs2      = rnd_reg();
    in_rd       = rnd_reg();
    in_regwrite = $urandom_range(0, 1);
    in_memread  = $urandom_range(0, 1);
    in_use_imm  = ($urandom_range(0, 3) == 0);
    in_imm      = rnd64();
    rf_data1    = rnd64();
    rf_data2    = rnd64();
    ex_valid    = $urandom_range(0, 1);
    ex_regwrite = ($urandom_range(0, 3) != 0);
    ex_memread  = ($urandom_range(0, 2) == 0);
    ex_rd       = rnd_reg();
    ex_result   = rnd64();
    mem_valid   = $urandom_range(0, 1);
    mem_regwrite= ($urandom_range(0, 3) != 0);
    mem_rd      = rnd_reg();
    mem_result  = rnd64();
    wb_valid    = $urandom_range(0, 1);
    wb_regwrite = ($urandom_range(0, 3) != 0);
    wb_rd       = rnd_reg();
    wb_data     = rnd64();
    flush       = ($urandom_range(0, 19) == 0);
    out_ready   = ($urandom_range(0, 9) < 7);
  endtask

  initial begin
    clear_inputs();
    reset_n = 0;
    m_reset();
    #3;
    check_outputs("reset");
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;

    // Independent operands, no hazards.
    clear_inputs();
    in_valid = 1; in_rs1 = 1; in_rs2 = 2; in_rd = 6; in_regwrite = 1;
    rf_data1 = 64'd5; rf_data2 = 64'd7;
    step("indep");
    check("indep.opa_const", out_opa, 64'd5);
    check("indep.opb_const", out_opb, 64'd7);

    // Forwarding priority EX > MEM > WB.
    in_rs1 = 3; rf_data1 = 64'h99;
    ex_valid = 1;  ex_regwrite = 1;  ex_rd = 3;  ex_result  = 64'hA;
    mem_valid = 1; mem_regwrite = 1; mem_rd = 3; mem_result = 64'hB;
    wb_valid = 1;  wb_regwrite = 1;  wb_rd = 3;  wb_data    = 64'hC;
    step("prio_ex");
    check("prio_ex.const", out_opa, 64'hA);
    ex_valid = 0;
    step("prio_mem");
    check("prio_mem.const", out_opa, 64'hB);
    mem_valid = 0;
    step("prio_wb");
    check("prio_wb.const", out_opa, 64'hC);
    wb_valid = 0;

    // Zero register is never forwarded.
    in_rs1 = 31; ex_valid = 1; ex_regwrite = 1; ex_rd = 31; ex_result = 64'hFF;
    rf_data1 = 64'h55;
    step("xzr");
    check("xzr.const", out_opa, 64'd0);

    // Load-use on rs2: one bubble, then MEM forwarding.
    clear_inputs();
    in_valid = 1; in_rs1 = 1; in_rs2 = 4; rf_data2 = 64'h77;
    ex_valid = 1; ex_regwrite = 1; ex_memread = 1; ex_rd = 4; ex_result = 64'hDEAD;
    step("lu_bubble");
    check("lu_bubble.count", stall_count, 1);
    ex_valid = 0; ex_memread = 0;
    mem_valid = 1; mem_regwrite = 1; mem_rd = 4; mem_result = 64'h1234;
    step("lu_resolve");
    check("lu_resolve.opb", out_opb, 64'h1234);

    // Same hazard with immediate operand B: no stall.
    clear_inputs();
    in_valid = 1; in_rs1 = 1; in_rs2 = 4; in_use_imm = 1; in_imm = 64'h42;
    ex_valid = 1; ex_regwrite = 1; ex_memread = 1; ex_rd = 4;
    step("lu_imm");
    check("lu_imm.count", stall_count, 1);

    // Backpressure for three cycles, then flush.
    clear_inputs();
    in_valid = 1; in_rs1 = 2; rf_data1 = 64'h1111; in_regwrite = 1;
    step("bp_load");
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_rs1 = 5'(i + 3); rf_data1 = rnd64();
      step($sformatf("bp_hold%0d", i));
    end
    flush = 1;
    step("flush");
    flush = 0; out_ready = 1;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      step($sformatf("rnd%0d", i));
    end

    // Reset in the middle of operation acts without a clock edge.
    clear_inputs();
    in_valid = 1; in_rs1 = 1; rf_data1 = 64'h3;
    step("pre_reset");
    out_ready = 0;
    #2;
    reset_n = 0;
    #1;
    m_reset();
    check_outputs("async_reset");
    @(negedge clk);
    reset_n = 1;
    clear_inputs();
    step("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Decode-to-execute pipeline stage that consumes the two register file read ports (ReadData1/ReadData2) for the instruction in decode. It resolves data hazards by forwarding from the EX, MEM and WB stages, and detects load-use hazards, inserting a bubble and stalling decode when one occurs. Resolved operands are registered into the ID/EX pipeline register behind a valid/ready handshake. It sits between the register file and the 64-bit ALU/execute stage.

## Interface
- XZR, default 31: register index hardwired to zero; never forwarded, never causes a hazard.
- CNT_W, default 32: width of the load-use stall counter.

- clk  input  1  pipeline clock; all state updates on rising edge.
- reset_n  input  1  one clock; reset is asynchronous and active-low.
- in_valid  input  1  decode holds a valid instruction.
- in_ready  output  1  stage accepts the decode instruction this cycle.
- in_rs1, in_rs2, in_rd  input  5  source and destination register indices; rs1/rs2 also drive the regfile read addresses.
- in_regwrite, in_memread, in_use_imm  input  1 each  control bits; in_use_imm selects in_imm for operand B.
- in_imm  input  64  sign-extended immediate.
- rf_data1, rf_data2  input  64  regfile read data for in_rs1/in_rs2, combinational in the same cycle.
- ex_valid, ex_regwrite, ex_memread  input  1 each  status of the instruction currently in EX.
- ex_rd  input  5  destination register of the EX instruction.
- ex_result  input  64  ALU result of the EX instruction.
- mem_valid, mem_regwrite  input  1 each  status of the MEM instruction.
- mem_rd  input  5  destination register of the MEM instruction.
- mem_result  input  64  final MEM result, including load data.
- wb_valid, wb_regwrite  input  1 each  status of the WB instruction, i.e. the regfile write port this cycle.
- wb_rd  input  5  destination register of the WB instruction.
- wb_data  input  64  value being written to the regfile this cycle.
- flush  input  1  kill the ID/EX contents and the decode instruction.
- out_valid  output  1  ID/EX register holds a valid instruction.
- out_ready  input  1  execute accepts the ID/EX contents.
- out_opa, out_opb  output  64  resolved operands.
- out_rd  output  5  destination register of the ID/EX instruction.
- out_regwrite, out_memread  output  1 each  control bits of the ID/EX instruction.
- out_store_data  output  64  forwarded rs2 value, independent of in_use_imm.
- stall_count  output  CNT_W  saturating count of load-use bubble cycles.

## Operation
- Forwarding per source `s` (rs1, rs2), in priority order:
  1. s == XZR gives 0.
  2. ex_valid & ex_regwrite & ex_rd==s gives ex_result.
  3. mem_valid & mem_regwrite & mem_rd==s gives mem_result.
  4. wb_valid & wb_regwrite & wb_rd==s gives wb_data, because the regfile write lands at the edge and the read would otherwise return the old value.
  5. Otherwise rf_data.
- Operand selection:
  - out_opa = fwd(rs1).
  - out_opb = in_use_imm ? in_imm : fwd(rs2).
  - out_store_data = fwd(rs2) always.
- load_use = in_valid & ex_valid & ex_memread & ex_regwrite & ex_rd != XZR & (ex_rd==in_rs1 | (ex_rd==in_rs2 & !in_use_imm)).
- in_ready = (!out_valid | out_ready) & !load_use. A flush overrides this and forces in_ready = 1 so decode drains.
- Register update enable = !out_valid | out_ready.
  - When enabled and not flushed: out_valid <= in_valid & !load_use, and the payload loads from decode.
  - On a load-use hazard a bubble is inserted. out_valid = 0, and payload contents are don't-care but must carry regwrite = memread = 0.
- flush: at the next edge out_valid <= 0 and out_regwrite <= out_memread <= 0, regardless of out_ready. The decode instruction is discarded. flush wins over all other events.
- stall_count increments once per edge at which a load-use bubble is inserted, i.e. the enable is true, load_use = 1 and flush = 0. It saturates at all ones.

## Timing
- Reset (async, reset_n low): out_valid = 0, out_regwrite = 0, out_memread = 0, out_opa = out_opb = out_store_data = 0, out_rd = 0, stall_count = 0. Outputs hold these values until the first rising edge after reset_n deasserts.
- Latency is one cycle from decode handshake (in_valid & in_ready) to out_valid.
- Throughput is one instruction per cycle when out_ready = 1 and there is no hazard.
- Backpressure: while out_valid & !out_ready, all out_* outputs are held stable and in_ready = 0.
- A load-use hazard costs exactly one bubble. On the next cycle the load is in MEM and is forwarded via mem_result.
- All forwarding is combinational within the decode cycle. Sampled values are those present at the capturing edge.

## Test plan
- Independent ops: rs1=1, rs2=2, rf_data=5/7, no hazards → next cycle out_opa=5, out_opb=7, out_valid=1.
- EX forward priority: ex_rd=mem_rd=wb_rd=3, results A/B/C, rs1=3 → out_opa=A. Repeat with ex_valid=0 → B, then mem_valid=0 → C.
- XZR: rs1=31, ex_rd=31 with regwrite, ex_result=0xFF → out_opa=0.
- Load-use: ex_memread=1, ex_rd=4, rs2=4, in_use_imm=0 → in_ready=0, one bubble (out_valid=0), stall_count=1. Next cycle mem_rd=4, mem_result=0x1234 → out_opb=0x1234. Same case with in_use_imm=1 → no stall.
- Backpressure plus flush: out_valid=1, out_ready=0 for 3 cycles → outputs stable and in_ready=0. Assert flush → next edge out_valid=0.
- Mid-operation reset: drop reset_n while out_valid=1 and stall_count=5 → out_valid and stall_count become 0 immediately, without waiting for a clock edge.
